// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// multiplier_arbiter : round-robin sharing of one start/done sequential multiplier
// Revision 1.0 - initial release
// ============================================================================
module multiplier_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*WIDTH-1:0]   a_flat_i,
    input  logic [N_REQ*WIDTH-1:0]   b_flat_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [2*WIDTH-1:0]       rsp_product_o,
    output logic                     rsp_err_o,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     mul_start_o,
    output logic [WIDTH-1:0]         mul_multiplicand_o,
    output logic [WIDTH-1:0]         mul_multiplier_o,
    input  logic [2*WIDTH-1:0]       mul_product_i,
    input  logic                     mul_done_i
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [OW-1:0]      ptr_q;
    logic [OW-1:0]      owner_q;
    logic               armed_q;
    logic               err_q;
    logic [CW-1:0]      cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic               mul_start_q;
    logic [2*WIDTH-1:0] rsp_product_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic               win_valid_d;
    logic [OW-1:0]      win_idx_d;
    logic [OW-1:0]      ptr_d;

    // Index arithmetic modulo N_REQ, which need not be a power of two.
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base,
                                               input logic [OW-1:0] off);
        logic [OW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (OW+1)'(N_REQ)) begin
            sum = sum - (OW+1)'(N_REQ);
        end
        return sum[OW-1:0];
    endfunction

    // Scanning from the farthest offset down leaves the nearest set bit as winner.
    always_comb begin
        win_valid_d = 1'b0;
        win_idx_d   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_add(ptr_q, OW'(i))]) begin
                win_valid_d = 1'b1;
                win_idx_d   = wrap_add(ptr_q, OW'(i));
            end
        end
    end

    assign ptr_d = wrap_add(owner_q, OW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            armed_q       <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            mul_start_q   <= 1'b0;
            rsp_product_q <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid_d) begin
                        owner_q     <= win_idx_d;
                        mcand_q     <= a_flat_i[win_idx_d*WIDTH +: WIDTH];
                        mplier_q    <= b_flat_i[win_idx_d*WIDTH +: WIDTH];
                        gnt_q       <= ONE_HOT0 << win_idx_d;
                        mul_start_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    armed_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done seen before any low cycle belongs to the previous operation.
                    if (mul_done_i && armed_q) begin
                        rsp_product_q <= mul_product_i;
                        rsp_valid_q   <= ONE_HOT0 << owner_q;
                        state_q       <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        rsp_product_q <= '0;
                        err_q         <= 1'b1;
                        rsp_valid_q   <= ONE_HOT0 << owner_q;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (!mul_done_i) begin
                            armed_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    ptr_q   <= ptr_d;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o              = gnt_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_product_o      = rsp_product_q;
    assign rsp_err_o          = err_q;
    assign busy_o             = (state_q != S_IDLE);
    assign owner_o            = owner_q;
    assign mul_start_o        = mul_start_q;
    assign mul_multiplicand_o = mcand_q;
    assign mul_multiplier_o   = mplier_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// tb_multiplier_arbiter : self-checking bench with a behavioural multiplier
// Revision 1.0 - initial release
// ============================================================================
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_product;
    logic           rsp_err;
    logic           busy;
    logic [1:0]     owner;
    logic           mul_start;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] mul_product;
    logic           mul_done;

    multiplier_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_i              (req),
        .a_flat_i           (a_flat),
        .b_flat_i           (b_flat),
        .gnt_o              (gnt),
        .rsp_valid_o        (rsp_valid),
        .rsp_product_o      (rsp_product),
        .rsp_err_o          (rsp_err),
        .busy_o             (busy),
        .owner_o            (owner),
        .mul_start_o        (mul_start),
        .mul_multiplicand_o (mcand),
        .mul_multiplier_o   (mplier),
        .mul_product_i      (mul_product),
        .mul_done_i         (mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: optional stale-done window, then low for m_lat cycles, then done held high.
    int     m_lat = 2;
    int     m_stale_cfg = 0;
    bit     m_rand = 1'b0;
    int     m_cnt = 0;
    int     m_stale = 0;
    bit     m_pend = 1'b0;
    longint m_prod = 0;

    always @(negedge clk) begin
        if (mul_start) begin
            m_prod = longint'($signed(mcand)) * longint'($signed(mplier));
            if (m_rand) begin
                m_cnt   = int'($urandom_range(1, 8));
                m_stale = int'($urandom_range(0, 2));
            end else begin
                m_cnt   = m_lat;
                m_stale = m_stale_cfg;
            end
            m_pend = 1'b1;
        end else if (m_pend) begin
            if (m_stale > 0) begin
                mul_done = 1'b1;
                m_stale--;
            end else if (m_cnt > 0) begin
                mul_done = 1'b0;
                m_cnt--;
            end else begin
                mul_done    = 1'b1;
                mul_product = m_prod;
                m_pend      = 1'b0;
            end
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [W-1:0] ta [N];
    logic [W-1:0] tb [N];

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        ta[i] = a;
        tb[i] = b;
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    task automatic wait_gnt(input int bound, output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("gnt arrives", 64'(gnt != '0), 64'd1);
    endtask

    task automatic wait_rsp(input int bound, output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp arrives", 64'(rsp_valid != '0), 64'd1);
    endtask

    task automatic single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp_p, input string tag);
        int c;
        @(negedge clk);
        set_op(idx, a, b);
        req = 4'b0001 << idx;
        @(negedge clk);
        chk({tag, " gnt"}, 64'(gnt), 64'(4'b0001 << idx));
        chk({tag, " mul_start"}, 64'(mul_start), 64'd1);
        chk({tag, " operand a"}, 64'(mcand), 64'(a));
        chk({tag, " operand b"}, 64'(mplier), 64'(b));
        req = '0;
        wait_rsp(60, c);
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(4'b0001 << idx));
        chk({tag, " product"}, rsp_product, exp_p);
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
        @(negedge clk);
        chk({tag, " rsp pulse ends"}, 64'(rsp_valid), 64'd0);
    endtask

    function automatic int rr(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0]  p;
    } vec_t;

    vec_t vt [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c;
        int          ei;
        int          mptr;
        int          seen;
        longint      ep;
        logic [3:0]  req_prev;
        logic [3:0]  eg;
        bit          busy_prev;
        int          qi[$];
        longint      qp[$];

        vt[0] = '{0, 32'd5,          -32'sd3,      -64'sd15};
        vt[1] = '{1, -32'sd7,        -32'sd9,      64'd63};
        vt[2] = '{2, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vt[3] = '{3, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        vt[4] = '{0, 32'h8000_0000,  32'd1,        64'hFFFF_FFFF_8000_0000};
        vt[5] = '{1, -32'sd1,        32'd1,        -64'sd1};

        rst_n = 1'b0; req = '0; a_flat = '0; b_flat = '0;
        mul_done = 1'b0; mul_product = '0;
        for (int i = 0; i < N; i++) begin ta[i] = '0; tb[i] = '0; end
        repeat (3) @(negedge clk);
        chk("reset gnt", 64'(gnt), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset owner", 64'(owner), 64'd0);
        chk("reset mul_start", 64'(mul_start), 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset product", rsp_product, 64'd0);
        chk("reset operands", 64'({mcand, mplier}), 64'd0);
        rst_n = 1'b1;

        // All four requesting at once: grant order follows the pointer from 0.
        @(negedge clk);
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 32'd7);
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_gnt(20, c);
            chk("all4 gnt order", 64'(gnt), 64'(4'b0001 << k));
            req[k] = 1'b0;
            wait_rsp(60, c);
            chk("all4 rsp_valid", 64'(rsp_valid), 64'(4'b0001 << k));
            chk("all4 product", rsp_product, 64'(7 * (k + 1)));
        end

        // Fairness: two requesters held high alternate.
        @(negedge clk);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(20, c);
            chk("fair gnt", 64'(gnt), 64'((k % 2 == 0) ? 4'b0001 : 4'b0010));
            wait_rsp(60, c);
            chk("fair rsp_valid", 64'(rsp_valid), 64'((k % 2 == 0) ? 4'b0001 : 4'b0010));
            if (k == 3) req = '0;
        end

        for (int v = 0; v < 6; v++) begin
            single(vt[v].idx, vt[v].a, vt[v].b, vt[v].p, $sformatf("vec%0d", v));
        end

        // Stale done left high from the previous operation must not complete this one.
        m_stale_cfg = 3; m_lat = 3;
        single(2, 32'd65536, 32'd65536, 64'd4294967296, "stale");
        seen = 0;
        repeat (15) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        chk("stale single response", 64'(seen), 64'd0);
        m_stale_cfg = 0; m_lat = 2;

        // Timeout: done never rises.
        @(negedge clk);
        set_op(0, 32'd3, 32'd3);
        req = 4'b0001; m_lat = 1000;
        @(negedge clk);
        chk("timeout gnt", 64'(gnt), 64'd1);
        req = '0;
        wait_rsp(60, c);
        chk("timeout latency", 64'(c), 64'(TO + 2));
        chk("timeout rsp_valid", 64'(rsp_valid), 64'd1);
        chk("timeout rsp_err", 64'(rsp_err), 64'd1);
        chk("timeout product", rsp_product, 64'd0);
        @(negedge clk);
        chk("timeout err pulse ends", 64'(rsp_err), 64'd0);
        m_lat = 2;
        single(1, 32'd6, -32'sd7, -64'sd42, "after timeout");

        // Reset in the middle of WAIT.
        @(negedge clk);
        set_op(0, 32'd9, 32'd9);
        req = 4'b0001; m_lat = 1000;
        @(negedge clk);
        chk("midrst gnt", 64'(gnt), 64'd1);
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst product", rsp_product, 64'd0);
        chk("midrst operands", 64'({mcand, mplier}), 64'd0);
        chk("midrst outputs", 64'({gnt, rsp_valid, rsp_err, mul_start, owner}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; m_lat = 2;
        seen = 0;
        repeat (30) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        chk("midrst no response", 64'(seen), 64'd0);
        set_op(1, 32'd10, 32'd11);
        set_op(2, 32'd12, -32'sd13);
        req = 4'b0110;
        @(negedge clk);
        chk("postrst ptr0 gnt", 64'(gnt), 64'b0010);
        chk("postrst owner", 64'(owner), 64'd1);
        req = 4'b0100;
        wait_rsp(60, c);
        chk("postrst rsp1", 64'(rsp_valid), 64'b0010);
        chk("postrst product1", rsp_product, 64'd110);
        wait_gnt(20, c);
        chk("postrst gnt2", 64'(gnt), 64'b0100);
        chk("postrst owner2", 64'(owner), 64'd2);
        req = '0;
        wait_rsp(60, c);
        chk("postrst rsp2", 64'(rsp_valid), 64'b0100);
        chk("postrst product2", rsp_product, -64'sd156);

        // Randomized traffic against a transaction-level round-robin model.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_rand = 1'b1; mptr = 0; req_prev = '0; busy_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            eg = '0;
            if (!busy_prev && req_prev != '0) eg = 4'b0001 << rr(req_prev, mptr);
            if (eg != '0 || gnt != '0) begin
                chk("rand gnt", 64'(gnt), 64'(eg));
                if (eg != '0 && gnt == eg) begin
                    ei = rr(req_prev, mptr);
                    chk("rand mul_start", 64'(mul_start), 64'd1);
                    chk("rand operands", 64'({mcand, mplier}), 64'({ta[ei], tb[ei]}));
                    qi.push_back(ei);
                    qp.push_back(longint'($signed(ta[ei])) * longint'($signed(tb[ei])));
                end
            end
            if (rsp_valid != '0) begin
                if (qi.size() == 0) begin
                    chk("rand unexpected rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    ei = qi.pop_front();
                    ep = qp.pop_front();
                    chk("rand rsp owner", 64'(rsp_valid), 64'(4'b0001 << ei));
                    chk("rand product", rsp_product, ep);
                    chk("rand rsp_err", 64'(rsp_err), 64'd0);
                    mptr = (ei + 1) % N;
                end
            end
            busy_prev = busy;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    if (cyc >= 2800 || $urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_op(i, $urandom, $urandom);
                end else if (!req[i] && cyc < 2800 && $urandom_range(0, 3) == 0) begin
                    set_op(i, $urandom, $urandom);
                    req[i] = 1'b1;
                end
            end
            req_prev = req;
        end
        chk("rand drained", 64'(qi.size()), 64'd0);
        chk("rand idle at end", 64'({busy, req}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
